// File: rtl/census_stream_ctrl.sv
`default_nettype none
// =============================================================================
// census_stream_ctrl - raster sequencer, edge suppression and sideband delay
//                      line for the census stage.      Revision: 1.0
// =============================================================================
module census_stream_ctrl #(
   parameter int IMG_WIDTH     = 640,
   parameter int IMG_HEIGHT    = 480,
   parameter int WINDOW_WIDTH  = 2,
   parameter int WINDOW_HEIGHT = 2,
   parameter int X_BITS        = 10,
   parameter int Y_BITS        = 9,
   parameter int LATENCY       = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              in_sof,
   output logic              in_ready,
   output logic              shift_en,
   output logic              out_valid,
   output logic [X_BITS-1:0] out_x,
   output logic [Y_BITS-1:0] out_y,
   output logic              out_eol,
   output logic              out_eof,
   output logic              frame_done,
   output logic              sync_err,
   output logic [15:0]       frame_count
);

   localparam int                D_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [X_BITS-1:0] X_LAST = X_BITS'(IMG_WIDTH - 1);
   localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(IMG_HEIGHT - 1);
   localparam logic [X_BITS-1:0] X_OFF  = X_BITS'(WINDOW_WIDTH - 1);
   localparam logic [Y_BITS-1:0] Y_OFF  = Y_BITS'(WINDOW_HEIGHT - 1);
   localparam logic [D_BITS-1:0] D_INIT = D_BITS'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [X_BITS-1:0]   x_q, x_d;
   logic [Y_BITS-1:0]   y_q, y_d;
   logic [D_BITS-1:0]   drain_q, drain_d;
   logic                frame_done_q, frame_done_d;
   logic                sync_err_q, sync_err_d;
   logic [15:0]         frame_count_q;

   logic                accept;
   logic                restart;
   logic [X_BITS-1:0]   pix_x;
   logic [Y_BITS-1:0]   pix_y;
   logic                pix_eol;
   logic                pix_eof;
   logic                hit;
   logic [X_BITS-1:0]   win_x;
   logic [Y_BITS-1:0]   win_y;

   logic [LATENCY-1:0]  pv_q;
   logic [LATENCY-1:0]  pe_q;
   logic [LATENCY-1:0]  pf_q;
   logic [X_BITS-1:0]   px_q [LATENCY];
   logic [Y_BITS-1:0]   py_q [LATENCY];

   assign in_ready = (state_q != ST_DRAIN);
   assign accept   = in_valid & in_ready;
   assign shift_en = accept & ((state_q == ST_RUN) | in_sof);

   // A start-of-frame pixel, or the first pixel out of IDLE, is always (0,0).
   assign restart  = in_sof | (state_q == ST_IDLE);
   assign pix_x    = restart ? '0 : x_q;
   assign pix_y    = restart ? '0 : y_q;
   assign pix_eol  = (pix_x == X_LAST);
   assign pix_eof  = pix_eol & (pix_y == Y_LAST);
   assign hit      = shift_en & (pix_x >= X_OFF) & (pix_y >= Y_OFF);
   assign win_x    = pix_x - X_OFF;
   assign win_y    = pix_y - Y_OFF;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      drain_d      = drain_q;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_RUN: begin
            if (shift_en) begin
               sync_err_d = (state_q == ST_RUN) & in_sof;
               if (pix_eof) begin
                  state_d = ST_DRAIN;
                  drain_d = D_INIT;
                  x_d     = '0;
                  y_d     = '0;
               end else begin
                  state_d = ST_RUN;
                  if (pix_eol) begin
                     x_d = '0;
                     y_d = pix_y + Y_BITS'(1);
                  end else begin
                     x_d = pix_x + X_BITS'(1);
                     y_d = pix_y;
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (drain_q == '0) begin
               state_d      = ST_IDLE;
               frame_done_d = 1'b1;
            end else begin
               drain_d = drain_q - D_BITS'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         x_q           <= '0;
         y_q           <= '0;
         drain_q       <= '0;
         frame_done_q  <= 1'b0;
         sync_err_q    <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         drain_q      <= drain_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         if (frame_done_d) begin
            frame_count_q <= frame_count_q + 16'd1;
         end
      end
   end

   // Census is free-running, so the sideband line shifts every cycle; idle
   // cycles become bubbles with valid low.
   always_ff @(posedge clk) begin
      if (rst) begin
         pv_q <= '0;
         pe_q <= '0;
         pf_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            px_q[i] <= '0;
            py_q[i] <= '0;
         end
      end else begin
         pv_q[0] <= hit;
         pe_q[0] <= hit & pix_eol;
         pf_q[0] <= hit & pix_eof;
         px_q[0] <= win_x;
         py_q[0] <= win_y;
         for (int i = 1; i < LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pe_q[i] <= pe_q[i-1];
            pf_q[i] <= pf_q[i-1];
            px_q[i] <= px_q[i-1];
            py_q[i] <= py_q[i-1];
         end
      end
   end

   assign out_valid   = pv_q[LATENCY-1];
   assign out_eol     = pe_q[LATENCY-1];
   assign out_eof     = pf_q[LATENCY-1];
   assign out_x       = px_q[LATENCY-1];
   assign out_y       = py_q[LATENCY-1];
   assign frame_done  = frame_done_q;
   assign sync_err    = sync_err_q;
   assign frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_census_stream_ctrl.sv
`default_nettype none
// tb_census_stream_ctrl - a 4x3/L1 and a 3x2/L3 instance share one stimulus
// stream; each is compared every cycle against a pixel-index frame model.
module tb_census_stream_ctrl;
   localparam int XB = 10;
   localparam int YB = 9;

   typedef struct packed {
      bit          v;
      bit [XB-1:0] x;
      bit [YB-1:0] y;
      bit          eol;
      bit          eof;
   } win_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic in_sof = 1'b0;
   always #5 clk = ~clk;

   logic          a_ready, a_shift, a_valid, a_eol, a_eof, a_done, a_serr;
   logic [XB-1:0] a_x;
   logic [YB-1:0] a_y;
   logic [15:0]   a_fc;
   logic          b_ready, b_shift, b_valid, b_eol, b_eof, b_done, b_serr;
   logic [XB-1:0] b_x;
   logic [YB-1:0] b_y;
   logic [15:0]   b_fc;

   census_stream_ctrl #(
      .IMG_WIDTH(4), .IMG_HEIGHT(3), .WINDOW_WIDTH(2), .WINDOW_HEIGHT(2),
      .X_BITS(XB), .Y_BITS(YB), .LATENCY(1)
   ) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .in_ready(a_ready), .shift_en(a_shift), .out_valid(a_valid),
      .out_x(a_x), .out_y(a_y), .out_eol(a_eol), .out_eof(a_eof),
      .frame_done(a_done), .sync_err(a_serr), .frame_count(a_fc)
   );

   census_stream_ctrl #(
      .IMG_WIDTH(3), .IMG_HEIGHT(2), .WINDOW_WIDTH(2), .WINDOW_HEIGHT(2),
      .X_BITS(XB), .Y_BITS(YB), .LATENCY(3)
   ) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .in_ready(b_ready), .shift_en(b_shift), .out_valid(b_valid),
      .out_x(b_x), .out_y(b_y), .out_eol(b_eol), .out_eof(b_eof),
      .frame_done(b_done), .sync_err(b_serr), .frame_count(b_fc)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int k, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%0d want=%0d at %0t", nm, k, act, exp, $time);
      end
   endtask

   // Model: per instance, frame position as a linear pixel index.
   int   cW[2] = '{4, 3};
   int   cH[2] = '{3, 2};
   int   cL[2] = '{1, 3};
   bit   m_in[2];
   int   m_n[2];
   int   m_dr[2];
   int   m_fc[2];
   bit   m_fd[2];
   bit   m_se[2];
   bit   m_all[2];
   win_t m_exp[2];
   win_t hist[2][64];
   int   edge_n = 1;
   int   rst_edge = 0;
   int   cyc = 0;

   // Event logs for the literal pins.
   int   logx[$];
   int   logy[$];
   int   logeol[$];
   int   logeof[$];
   int   nshift, nserr, nfd, nnr_a, nnr_b, nbv, b_last, b_done_cyc;

   task automatic clear_logs();
      logx.delete(); logy.delete(); logeol.delete(); logeof.delete();
      nshift = 0; nserr = 0; nfd = 0; nnr_a = 0; nnr_b = 0; nbv = 0;
      b_last = 0; b_done_cyc = 0;
   endtask

   always @(negedge clk) begin : cmp
      int   av[2], ax[2], ay[2], al[2], af[2], ad[2], ase[2], afc[2], ar[2], ash[2];
      bit   ready, acc, shx;
      int   p, x, y, idx;
      win_t w;
      av[0] = int'(a_valid); av[1] = int'(b_valid);
      ax[0] = int'(a_x);     ax[1] = int'(b_x);
      ay[0] = int'(a_y);     ay[1] = int'(b_y);
      al[0] = int'(a_eol);   al[1] = int'(b_eol);
      af[0] = int'(a_eof);   af[1] = int'(b_eof);
      ad[0] = int'(a_done);  ad[1] = int'(b_done);
      ase[0] = int'(a_serr); ase[1] = int'(b_serr);
      afc[0] = int'(a_fc);   afc[1] = int'(b_fc);
      ar[0] = int'(a_ready); ar[1] = int'(b_ready);
      ash[0] = int'(a_shift); ash[1] = int'(b_shift);
      cyc++;
      for (int k = 0; k < 2; k++) begin
         chk("out_valid", k, av[k], int'(m_exp[k].v));
         if (m_exp[k].v || m_all[k]) begin
            chk("out_x", k, ax[k], int'(m_exp[k].x));
            chk("out_y", k, ay[k], int'(m_exp[k].y));
            chk("out_eol", k, al[k], int'(m_exp[k].eol));
            chk("out_eof", k, af[k], int'(m_exp[k].eof));
         end
         chk("frame_done", k, ad[k], int'(m_fd[k]));
         chk("sync_err", k, ase[k], int'(m_se[k]));
         chk("frame_count", k, afc[k], m_fc[k]);
         if (!rst) begin
            ready = (m_dr[k] == 0);
            acc   = in_valid && ready;
            shx   = acc && (m_in[k] || in_sof);
            chk("in_ready", k, ar[k], int'(ready));
            chk("shift_en", k, ash[k], int'(shx));
         end
      end
      if (!rst) begin
         if (a_valid) begin
            logx.push_back(ax[0]); logy.push_back(ay[0]);
            logeol.push_back(al[0]); logeof.push_back(af[0]);
         end
         if (a_shift) nshift++;
         if (a_serr)  nserr++;
         if (a_done)  nfd++;
         if (!a_ready) nnr_a++;
         if (!b_ready) nnr_b++;
         if (b_valid) nbv++;
         if (b_shift) b_last = cyc;
         if (b_done)  b_done_cyc = cyc;
      end
      // Advance the model across the coming clock edge.
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_in[k] = 0; m_n[k] = 0; m_dr[k] = 0; m_fc[k] = 0;
            m_fd[k] = 0; m_se[k] = 0; m_exp[k] = '0; m_all[k] = 1;
         end else begin
            m_all[k] = 0; m_fd[k] = 0; m_se[k] = 0; w = '0;
            ready = (m_dr[k] == 0);
            shx   = in_valid && ready && (m_in[k] || in_sof);
            if (!ready) begin
               m_dr[k]--;
               if (m_dr[k] == 0) begin
                  m_fd[k] = 1;
                  m_fc[k] = (m_fc[k] + 1) % 65536;
               end
            end else if (shx) begin
               if (in_sof) begin
                  if (m_in[k]) m_se[k] = 1;
                  m_n[k] = 0;
               end
               p = m_n[k];
               x = p % cW[k];
               y = p / cW[k];
               if (x >= 1 && y >= 1) begin
                  w.v   = 1;
                  w.x   = XB'(x - 1);
                  w.y   = YB'(y - 1);
                  w.eol = (x == cW[k] - 1);
                  w.eof = (p == cW[k] * cH[k] - 1);
               end
               m_n[k]  = p + 1;
               m_in[k] = 1;
               if (p == cW[k] * cH[k] - 1) begin
                  m_in[k] = 0;
                  m_dr[k] = cL[k];
               end
            end
            hist[k][edge_n % 64] = w;
            idx = edge_n - cL[k] + 1;
            m_exp[k] = (idx > rst_edge) ? hist[k][idx % 64] : '0;
         end
      end
      if (rst) rst_edge = edge_n;
      edge_n++;
   end

   task automatic px(input bit v, input bit s);
      @(posedge clk);
      #1;
      in_valid = v;
      in_sof   = s;
   endtask

   int exx[6] = '{0, 1, 2, 0, 1, 2};
   int exy[6] = '{0, 0, 0, 1, 1, 1};

   initial begin
      clear_logs();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #3;
      chk("rst_ready", 0, int'(a_ready), 1);
      chk("rst_ready", 1, int'(b_ready), 1);
      chk("rst_valid", 0, int'(a_valid), 0);
      chk("rst_x", 0, int'(a_x), 0);
      chk("rst_fc", 0, int'(a_fc), 0);

      // Full frame with valid held high.
      clear_logs();
      for (int i = 0; i < 12; i++) px(1'b1, i == 0);
      repeat (6) px(1'b0, 1'b0);
      chk("s1_shift", 0, nshift, 12);
      chk("s1_wins", 0, logx.size(), 6);
      for (int i = 0; i < 6; i++) begin
         if (i < logx.size()) begin
            chk("s1_x", 0, logx[i], exx[i]);
            chk("s1_y", 0, logy[i], exy[i]);
            chk("s1_eol", 0, logeol[i], int'(i % 3 == 2));
            chk("s1_eof", 0, logeof[i], int'(i == 5));
         end
      end
      chk("s1_notready", 0, nnr_a, 1);
      chk("s1_done", 0, nfd, 1);
      chk("s1_fc", 0, int'(a_fc), 1);
      chk("s6_wins", 1, nbv, 2);
      chk("s6_notready", 1, nnr_b, 3);
      chk("s6_done_lag", 1, b_done_cyc - b_last, 4);

      // Valid toggling.
      clear_logs();
      for (int i = 0; i < 24; i++) px(i % 2 == 0, i == 0);
      repeat (4) px(1'b0, 1'b0);
      chk("s2_shift", 0, nshift, 12);
      chk("s2_wins", 0, logx.size(), 6);
      chk("s2_fc", 0, int'(a_fc), 2);

      // Stray pixels in IDLE, then a frame.
      clear_logs();
      for (int i = 0; i < 5; i++) px(1'b1, 1'b0);
      for (int i = 0; i < 12; i++) px(1'b1, i == 0);
      repeat (6) px(1'b0, 1'b0);
      chk("s3_shift", 0, nshift, 12);
      chk("s3_wins", 0, logx.size(), 6);

      // Resync at pixel index 7.
      clear_logs();
      for (int i = 0; i < 7; i++) px(1'b1, i == 0);
      for (int i = 0; i < 12; i++) px(1'b1, i == 0);
      repeat (6) px(1'b0, 1'b0);
      chk("s4_serr", 0, nserr, 1);
      chk("s4_done", 0, nfd, 1);
      chk("s4_wins", 0, logx.size(), 8);
      chk("s4_fc", 0, int'(a_fc), 4);

      // Reset mid-frame at pixel index 6.
      clear_logs();
      for (int i = 0; i < 6; i++) px(1'b1, i == 0);
      @(posedge clk);
      #1 rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0;
      #3;
      chk("s5_valid", 0, int'(a_valid), 0);
      chk("s5_done", 0, int'(a_done), 0);
      chk("s5_ready", 0, int'(a_ready), 1);
      chk("s5_fc", 0, int'(a_fc), 0);
      for (int i = 0; i < 12; i++) px(1'b1, i == 0);
      repeat (6) px(1'b0, 1'b0);
      chk("s5_fc_after", 0, int'(a_fc), 1);

      // Randomised traffic with occasional resync and reset.
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         in_valid = ($urandom_range(0, 99) < 70);
         in_sof   = in_valid && ($urandom_range(0, 99) < 6);
         rst      = ($urandom_range(0, 399) == 0);
      end
      @(posedge clk);
      #1 rst = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/census_stream_ctrl.md
# census_stream_ctrl

Sequencer for the census stage of the stereo pipeline. It accepts the raw pixel valid/start-of-frame strobes and tracks each pixel's raster position. It drives the line-buffer shift enable and produces valid, coordinate and end-of-line/end-of-frame sideband delayed to line up with the registered census output. It also suppresses windows that are not yet fully populated at the image's top and left edges, and drains the pipeline before accepting the next frame.

## Interface
- IMG_WIDTH, 640, pixels per line (≥ WINDOW_WIDTH)
- IMG_HEIGHT, 480, lines per frame (≥ WINDOW_HEIGHT)
- WINDOW_WIDTH, 2, census window width
- WINDOW_HEIGHT, 2, census window height
- X_BITS, 10, column counter width; 2^X_BITS ≥ IMG_WIDTH
- Y_BITS, 9, row counter width; 2^Y_BITS ≥ IMG_HEIGHT
- LATENCY, 1, cycles from line-buffer shift to census output (≥ 1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  pixel present this cycle
- in_sof  in  1  qualifies in_valid: pixel is (0,0) of a new frame
- in_ready  out  1  combinational; high in IDLE and RUN, low in DRAIN
- shift_en  out  1  combinational; pixel accepted into frame, advance line buffers
- out_valid  out  1  census output word is a complete window
- out_x  out  X_BITS  window top-left column
- out_y  out  Y_BITS  window top-left row
- out_eol  out  1  with out_valid: last window of a line
- out_eof  out  1  with out_valid: last window of the frame
- frame_done  out  1  one-cycle pulse, pipeline drained
- sync_err  out  1  one-cycle pulse, in_sof seen mid-frame
- frame_count  out  16  completed frames, wraps

## Operation
- Accept = in_valid & in_ready.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - An accepted pixel with in_sof sets (x,y)=(0,0), asserts shift_en and goes to RUN.
  - An accepted pixel without in_sof is dropped: shift_en low, no count.
- RUN: every accepted pixel asserts shift_en. The position then advances:
  - x increments.
  - At x=IMG_WIDTH-1, x wraps to 0 and y increments.
  - Accepting (IMG_WIDTH-1, IMG_HEIGHT-1) moves to DRAIN with drain counter = LATENCY-1.
- RUN with in_sof on an accepted pixel:
  - sync_err pulses next cycle.
  - The pixel is treated as (0,0) of a new frame and counters restart.
  - frame_count is not incremented and frame_done does not pulse.
- DRAIN:
  - in_ready is low.
  - The drain counter decrements each cycle.
  - At 0, the state returns to IDLE; next cycle frame_done pulses and frame_count increments.
- Window hit (combinational, on accepted pixel at position x,y): x ≥ WINDOW_WIDTH-1 and y ≥ WINDOW_HEIGHT-1.
  - Coordinates: (x-(WINDOW_WIDTH-1), y-(WINDOW_HEIGHT-1)).
  - eol = x==IMG_WIDTH-1.
  - eof = eol & y==IMG_HEIGHT-1.
- Hit, coordinates, eol and eof enter a LATENCY-deep register pipeline that advances every cycle, because census is free-running.
  - Bubbles (no accept) propagate as out_valid=0.
  - out_x, out_y, out_eol and out_eof are don't-care when out_valid=0 but must be zero after reset.
- Valid windows per frame: (IMG_WIDTH-WINDOW_WIDTH+1)*(IMG_HEIGHT-WINDOW_HEIGHT+1), in raster order.

## Timing
- shift_en and in_ready are combinational from state, in_valid and in_sof.
- Pixel accepted at cycle t → matching out_valid/out_x/out_y at cycle t+LATENCY.
- Last pixel at t: DRAIN for cycles t+1..t+LATENCY; out_eof at t+LATENCY; IDLE, frame_done and in_ready=1 at t+LATENCY+1.
- sync_err and frame_done are registered single-cycle pulses.
- Reset values: state IDLE, x=y=0, drain counter 0, all pipeline stages cleared.
  - Outputs: out_valid, out_x, out_y, out_eol, out_eof, frame_done, sync_err = 0; frame_count = 0.
  - in_ready=1 during the cycle after reset release.
- Reset mid-frame or mid-drain: pending pipeline valids are discarded, with no frame_done and no out_eof.
- Reset has priority over every other event in the same cycle.
- frame_count wraps 0xFFFF→0.

## Test plan
Configuration for all scenarios unless stated: IMG 4×3, window 2×2, LATENCY 1.

- Frame streamed with in_valid held high, sof on pixel 0 → 12 shift_en pulses and 6 out_valid in order: (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - out_eol on x=2; out_eof only on (2,1), one cycle after the last accept.
  - in_ready low for 1 cycle, then frame_done=1 and frame_count=1.
- Same frame with in_valid toggling 1,0 → identical window sequence; each out_valid exactly 1 cycle after its accept; no out_valid in bubble-following cycles.
- In IDLE, 5 pixels without sof, then a frame → first 5 produce no shift_en and no outputs; frame then behaves as in scenario 1.
- in_sof asserted at pixel index 7 of a frame:
  - sync_err pulses once and counters restart.
  - A further 12 pixels complete one frame with frame_count=1, not 2.
- rst asserted for one cycle at pixel index 6 → all outputs 0 the next cycle, state IDLE, no frame_done; a following frame completes normally.
- LATENCY=3, IMG 3×2 → 2 windows; each out_valid trails its accept by 3 cycles; in_ready low for 3 cycles after the last pixel; frame_done 4 cycles after the last accept.
